// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin register-file writeback arbiter with optional busy scoreboard (macro RF_WB_SCOREBOARD_EN)
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0][4:0]       req_idx,
  input  logic [NREQ-1:0][XLEN-1:0]  req_data,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       wb_stall,
  output logic                       wr_en,
  output logic [4:0]                 wr_idx,
  output logic [XLEN-1:0]            wr_data,
  input  logic                       iss_valid,
  input  logic [4:0]                 iss_idx,
  output logic [31:0]                busy
);

  logic [1:0]      last_q, last_d;
  logic            wr_en_q, wr_en_d;
  logic [4:0]      wr_idx_q, wr_idx_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;

  logic            handshake;
  logic [1:0]      gnt_sel;
  logic [2:0]      cand;
  logic [4:0]      gnt_idx;
  logic [XLEN-1:0] gnt_data;

  // Round-robin search starting one past the last granted requester; ready is
  // forced low during reset and stall so nothing is accepted then.
  always_comb begin
    req_ready = '0;
    handshake = 1'b0;
    gnt_sel   = '0;
    cand      = '0;
    if (reset_n && !wb_stall) begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = {1'b0, last_q} + 3'(k);
        if (cand >= 3'(NREQ)) cand = cand - 3'(NREQ);
        if (!handshake && req_valid[cand[1:0]]) begin
          handshake = 1'b1;
          gnt_sel   = cand[1:0];
        end
      end
    end
    if (handshake) req_ready[gnt_sel] = 1'b1;
  end

  assign gnt_idx  = req_idx[gnt_sel];
  assign gnt_data = req_data[gnt_sel];

  // Next-state for priority pointer and write port; x0 writes are accepted but never enabled.
  always_comb begin
    last_d    = last_q;
    wr_en_d   = 1'b0;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    if (handshake) begin
      last_d    = gnt_sel;
      wr_en_d   = (gnt_idx != 5'd0);
      wr_idx_d  = gnt_idx;
      wr_data_d = gnt_data;
    end
  end

  // Write-port and pointer registers; reset makes requester 0 the first priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q    <= 2'(NREQ - 1);
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else begin
      last_q    <= last_d;
      wr_en_q   <= wr_en_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_idx  = wr_idx_q;
  assign wr_data = wr_data_q;

`ifdef RF_WB_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;

  // Clear on writeback, then set on issue so a same-cycle re-issue stays pending; x0 never busy.
  always_comb begin
    busy_d = busy_q;
    if (handshake) busy_d[gnt_idx] = 1'b0;
    if (iss_valid) busy_d[iss_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Pending-writeback scoreboard register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign busy = busy_q;
`else
  logic unused_iss;
  assign unused_iss = ^{iss_valid, iss_idx};
  assign busy       = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
  localparam int N = 3;
`ifdef RF_WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [N-1:0]           req_valid;
  logic [N-1:0][4:0]      req_idx;
  logic [N-1:0][31:0]     req_data;
  logic [N-1:0]           req_ready;
  logic                   wb_stall;
  logic                   wr_en;
  logic [4:0]             wr_idx;
  logic [31:0]            wr_data;
  logic                   iss_valid;
  logic [4:0]             iss_idx;
  logic [31:0]            busy;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.NREQ(N), .XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_idx(req_idx),
    .req_data(req_data), .req_ready(req_ready), .wb_stall(wb_stall),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_idx(iss_idx), .busy(busy)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model state
  int          m_last;
  logic        m_en;
  logic [4:0]  m_idx;
  logic [31:0] m_data;
  logic [31:0] m_busy;

  function automatic int model_grant(input logic [N-1:0] v, input logic st, input int last);
    if (st) return -1;
    for (int off = 1; off <= N; off++) begin
      int r;
      r = (last + off) % N;
      if (v[r]) return r;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    req_valid = '1;
    req_idx   = {5'd3, 5'd2, 5'd1};
    req_data  = '1;
    wb_stall  = 1'b0;
    iss_valid = 1'b0;
    iss_idx   = '0;
    reset_n   = 1'b0;
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_idx", wr_idx, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    req_valid = '0;
    req_data  = '0;
    reset_n   = 1'b1;
    m_last = N - 1; m_en = 0; m_idx = 0; m_data = 0; m_busy = 0;
  endtask

  typedef struct {
    logic [N-1:0]       v;
    logic [N-1:0][4:0]  idx;
    logic [N-1:0][31:0] data;
    logic               st;
    logic [N-1:0]       rdy;
    logic               en;
    logic [4:0]         widx;
    logic [31:0]        wdata;
  } vec_t;

  vec_t tbl[8];

  logic [N-1:0]       pv;
  logic [N-1:0][4:0]  ridx;
  logic [N-1:0][31:0] rdat;
  int                 waits[N];
  int                 g;

  initial begin
    reset_n = 1'b0; req_valid = '0; req_idx = '0; req_data = '0;
    wb_stall = 1'b0; iss_valid = 1'b0; iss_idx = '0;

    tbl[0] = '{3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF}, 1'b0, 3'b001, 1'b1, 5'd5, 32'hDEADBEEF};
    tbl[1] = '{3'b010, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h11111111, 32'h0}, 1'b0, 3'b010, 1'b0, 5'd0, 32'h0};
    tbl[2] = '{3'b111, {5'd9, 5'd8, 5'd7}, {32'hC2, 32'hC1, 32'hC0}, 1'b1, 3'b000, 1'b0, 5'd0, 32'h0};
    tbl[3] = '{3'b111, {5'd9, 5'd8, 5'd7}, {32'hC2, 32'hC1, 32'hC0}, 1'b1, 3'b000, 1'b0, 5'd0, 32'h0};
    tbl[4] = '{3'b111, {5'd9, 5'd8, 5'd7}, {32'hC2, 32'hC1, 32'hC0}, 1'b0, 3'b100, 1'b1, 5'd9, 32'hC2};
    tbl[5] = '{3'b111, {5'd9, 5'd8, 5'd7}, {32'hC2, 32'hC1, 32'hC0}, 1'b0, 3'b001, 1'b1, 5'd7, 32'hC0};
    tbl[6] = '{3'b110, {5'd9, 5'd8, 5'd7}, {32'hC2, 32'hC1, 32'hC0}, 1'b0, 3'b010, 1'b1, 5'd8, 32'hC1};
    tbl[7] = '{3'b000, {5'd9, 5'd8, 5'd7}, {32'hC2, 32'hC1, 32'hC0}, 1'b0, 3'b000, 1'b0, 5'd0, 32'h0};

    // Table-driven vectors
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      req_valid = tbl[i].v; req_idx = tbl[i].idx; req_data = tbl[i].data; wb_stall = tbl[i].st;
      #2;
      chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].rdy);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_wr_en", i), wr_en, tbl[i].en);
      if (tbl[i].en) begin
        chk($sformatf("tbl%0d_wr_idx", i), wr_idx, tbl[i].widx);
        chk($sformatf("tbl%0d_wr_data", i), wr_data, tbl[i].wdata);
      end
      @(negedge clk);
    end

    // All three held valid after reset: 0,1,2 then wrap to 0
    apply_reset();
    req_valid = 3'b111; req_idx = {5'd3, 5'd2, 5'd1}; req_data = {32'hA2, 32'hA1, 32'hA0};
    for (int i = 0; i < 4; i++) begin
      #2;
      chk($sformatf("rr%0d_ready", i), req_ready, 3'b001 << (i % 3));
      @(posedge clk); #1;
      chk($sformatf("rr%0d_wr_idx", i), wr_idx, 5'((i % 3) + 1));
      @(negedge clk);
    end

    // Stall for two cycles, then grant goes to requester 0
    apply_reset();
    req_valid = 3'b111; wb_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      chk("stall_ready", req_ready, 0);
      @(posedge clk); #1;
      chk("stall_wr_en", wr_en, 0);
      @(negedge clk);
    end
    wb_stall = 1'b0;
    #2;
    chk("release_ready", req_ready, 3'b001);
    @(negedge clk);

    // Reset asserted while a write is being presented
    apply_reset();
    req_valid = 3'b001; req_idx = {5'd0, 5'd0, 5'd5}; req_data = {32'h0, 32'h0, 32'hDEADBEEF};
    iss_valid = 1'b1; iss_idx = 5'd9;
    @(posedge clk); #1;
    chk("mid_wr_en_pre", wr_en, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_wr_en", wr_en, 0);
    chk("mid_wr_data", wr_data, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ready", req_ready, 0);
    iss_valid = 1'b0;
    @(negedge clk);
    req_valid = '0;
    reset_n = 1'b1;

    // Scoreboard set/clear and set-over-clear priority
    apply_reset();
    iss_valid = 1'b1; iss_idx = 5'd7;
    @(posedge clk); #1;
    chk("sb_set", busy[7], SB);
    @(negedge clk);
    iss_valid = 1'b0;
    req_valid = 3'b001; req_idx = {5'd0, 5'd0, 5'd7};
    @(posedge clk); #1;
    chk("sb_clear", busy[7], 0);
    @(negedge clk);
    iss_valid = 1'b1;
    @(posedge clk); #1;
    chk("sb_set_wins", busy[7], SB);
    @(negedge clk);
    iss_valid = 1'b1; iss_idx = 5'd0; req_valid = '0;
    @(posedge clk); #1;
    chk("sb_x0", busy[0], 0);
    @(negedge clk);
    iss_valid = 1'b0;

    // Randomized traffic against the reference model
    apply_reset();
    pv = '0; ridx = '0; rdat = '0;
    for (int i = 0; i < N; i++) waits[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 2) != 0) begin
          pv[i] = 1'b1;
          ridx[i] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
          rdat[i] = $urandom;
        end
      end
      req_valid = pv; req_idx = ridx; req_data = rdat;
      wb_stall  = ($urandom_range(0, 3) == 0);
      iss_valid = $urandom_range(0, 1);
      iss_idx   = 5'($urandom_range(0, 31));
      #2;
      g = model_grant(pv, wb_stall, m_last);
      chk("rnd_ready", req_ready, (g < 0) ? 0 : (3'b001 << g));
      @(posedge clk); #1;
      if (g >= 0) begin
        m_last = g;
        m_idx  = ridx[g];
        m_data = rdat[g];
        m_en   = (ridx[g] != 5'd0);
        if (SB) m_busy[ridx[g]] = 1'b0;
        chk("rnd_fairness", waits[g] <= N - 1, 1);
        for (int i = 0; i < N; i++) if (pv[i] && i != g) waits[i]++;
        waits[g] = 0;
        pv[g] = 1'b0;
      end else begin
        m_en = 1'b0;
      end
      if (SB && iss_valid) m_busy[iss_idx] = 1'b1;
      m_busy[0] = 1'b0;
      chk("rnd_wr_en", wr_en, m_en);
      chk("rnd_wr_idx", wr_idx, m_idx);
      chk("rnd_wr_data", wr_data, m_data);
      chk("rnd_busy", busy, m_busy);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
